// File: rtl/id_stage.sv
// Instruction decode stage: register file, control decode, load-use hazard
// detection, branch squash, and the ID/EX pipeline register.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       IF_ID_INSTR,
    input  logic [DATA_W-1:0] IF_ID_NPC,
    input  logic              BRANCH,
    input  logic              WB_REGWRITE,
    input  logic [4:0]        WB_WRITE_REG,
    input  logic [DATA_W-1:0] WB_WRITE_DATA,
    output logic              PC_WRITE,
    output logic              IFIDWrite,
    output logic [DATA_W-1:0] ID_EX_NPC,
    output logic [DATA_W-1:0] ID_EX_RS_DATA,
    output logic [DATA_W-1:0] ID_EX_RT_DATA,
    output logic [DATA_W-1:0] ID_EX_IMM,
    output logic [4:0]        ID_EX_RS,
    output logic [4:0]        ID_EX_RT,
    output logic [4:0]        ID_EX_RD,
    output logic              ID_EX_REGDST,
    output logic              ID_EX_ALUSRC,
    output logic              ID_EX_MEMREAD,
    output logic              ID_EX_MEMWRITE,
    output logic              ID_EX_MEMTOREG,
    output logic              ID_EX_REGWRITE,
    output logic              ID_EX_BRANCH,
    output logic [1:0]        ID_EX_ALUOP
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Control vector: {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, ALUOp[1:0]}
    localparam logic [8:0] CTRL_RTYPE = 9'b1_0_0_0_0_1_0_10;
    localparam logic [8:0] CTRL_LW    = 9'b0_1_1_0_1_1_0_00;
    localparam logic [8:0] CTRL_SW    = 9'b0_1_0_1_0_0_0_00;
    localparam logic [8:0] CTRL_BEQ   = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] CTRL_ADDI  = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] CTRL_NONE  = 9'b0;

    function automatic logic signed [DATA_W-1:0] sign_ext16(input logic signed [15:0] v);
        return DATA_W'(v);
    endfunction

    logic [DATA_W-1:0] rf [NREG];
    logic              sq;
    logic [8:0]        ctrl_p1;

    logic [5:0]               opcode_p0;
    logic [4:0]               rs_p0, rt_p0, rd_p0;
    logic [8:0]               ctrl_p0;
    logic                     known_p0;
    logic                     rt_used_p0;
    logic                     stall_p0;
    logic                     bubble_p0;
    logic [DATA_W-1:0]        rs_data_p0, rt_data_p0;
    logic signed [DATA_W-1:0] imm_p0;

    assign opcode_p0 = IF_ID_INSTR[31:26];
    assign rs_p0     = IF_ID_INSTR[25:21];
    assign rt_p0     = IF_ID_INSTR[20:16];
    assign rd_p0     = IF_ID_INSTR[15:11];
    assign imm_p0    = sign_ext16(IF_ID_INSTR[15:0]);

    always_comb begin
        ctrl_p0  = CTRL_NONE;
        known_p0 = 1'b1;
        case (opcode_p0)
            OP_RTYPE: ctrl_p0 = CTRL_RTYPE;
            OP_LW:    ctrl_p0 = CTRL_LW;
            OP_SW:    ctrl_p0 = CTRL_SW;
            OP_BEQ:   ctrl_p0 = CTRL_BEQ;
            OP_ADDI:  ctrl_p0 = CTRL_ADDI;
            default:  known_p0 = 1'b0;
        endcase
    end

    // Only these opcodes read rt as a source; lw/addi use it as a destination.
    assign rt_used_p0 = (opcode_p0 == OP_RTYPE) || (opcode_p0 == OP_SW) || (opcode_p0 == OP_BEQ);

    assign stall_p0 = ID_EX_MEMREAD && (ID_EX_RT != 5'd0) &&
                      ((ID_EX_RT == rs_p0) || ((ID_EX_RT == rt_p0) && rt_used_p0));

    assign bubble_p0 = stall_p0 || BRANCH || sq || !known_p0;

    assign PC_WRITE  = !RST || BRANCH || !stall_p0;
    assign IFIDWrite = !RST || BRANCH || !stall_p0;

    // Write-first bypass so a same-cycle write-back is visible to decode.
    always_comb begin
        rs_data_p0 = rf[rs_p0];
        rt_data_p0 = rf[rt_p0];
        if (WB_REGWRITE && WB_WRITE_REG == rs_p0) rs_data_p0 = WB_WRITE_DATA;
        if (WB_REGWRITE && WB_WRITE_REG == rt_p0) rt_data_p0 = WB_WRITE_DATA;
        if (rs_p0 == 5'd0) rs_data_p0 = '0;
        if (rt_p0 == 5'd0) rt_data_p0 = '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (WB_REGWRITE && WB_WRITE_REG != 5'd0) begin
            rf[WB_WRITE_REG] <= WB_WRITE_DATA;
        end
    end

    // ID -> EX boundary
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sq            <= 1'b0;
            ctrl_p1       <= CTRL_NONE;
            ID_EX_NPC     <= '0;
            ID_EX_RS_DATA <= '0;
            ID_EX_RT_DATA <= '0;
            ID_EX_IMM     <= '0;
            ID_EX_RS      <= '0;
            ID_EX_RT      <= '0;
            ID_EX_RD      <= '0;
        end else begin
            sq            <= BRANCH;
            ctrl_p1       <= bubble_p0 ? CTRL_NONE : ctrl_p0;
            ID_EX_NPC     <= IF_ID_NPC;
            ID_EX_RS_DATA <= rs_data_p0;
            ID_EX_RT_DATA <= rt_data_p0;
            ID_EX_IMM     <= imm_p0;
            ID_EX_RS      <= rs_p0;
            ID_EX_RT      <= rt_p0;
            ID_EX_RD      <= rd_p0;
        end
    end

    assign {ID_EX_REGDST, ID_EX_ALUSRC, ID_EX_MEMREAD, ID_EX_MEMWRITE,
            ID_EX_MEMTOREG, ID_EX_REGWRITE, ID_EX_BRANCH, ID_EX_ALUOP} = ctrl_p1;

endmodule
